// File: rtl/calc_sequencer.sv
// Command sequencer for the 32-entry stack/queue calculator memory.
// Define CALC_MUL_EN to enable op 011 (MUL); otherwise MUL is rejected with code 11.
module calc_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [31:0] cmd_data,
   input  logic        cmd_mode,
   output logic        mem_push,
   output logic        mem_pop,
   output logic        mem_stackQueue,
   output logic [31:0] mem_dataIn,
   input  logic [31:0] mem_stackOut,
   input  logic [31:0] mem_queueOut,
   input  logic        mem_empty,
   input  logic        mem_full,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic [1:0]  rsp_code,
   output logic [5:0]  depth
);

   typedef enum logic [2:0] {S_IDLE, S_POP1, S_POP2, S_PUSHW, S_RESP} state_t;
   typedef enum logic [2:0] {
      OP_PUSH = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_MUL = 3'd3,
      OP_AND  = 3'd4, OP_OR  = 3'd5, OP_XOR = 3'd6, OP_POP = 3'd7
   } op_t;

   localparam logic [1:0] RC_OK    = 2'b00;
   localparam logic [1:0] RC_UNDER = 2'b01;
   localparam logic [1:0] RC_OVER  = 2'b10;
   localparam logic [1:0] RC_ILL   = 2'b11;

`ifdef CALC_MUL_EN
   localparam logic MUL_EN = 1'b1;
`else
   localparam logic MUL_EN = 1'b0;
`endif

   state_t      state_q, state_d;
   op_t         op_q, op_d, acc_op;
   logic        mode_q, mode_d;
   logic [31:0] data_q, data_d;
   logic [31:0] opr_q, opr_d;
   logic [5:0]  depth_q, depth_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        rsp_err_q, rsp_err_d;
   logic [1:0]  rsp_code_q, rsp_code_d;

   logic [31:0] rd_data, opa, opb, alu_res;
   logic [1:0]  acc_code;
   logic        is_full, is_empty;

   assign rd_data = mode_q ? mem_queueOut : mem_stackOut;
   assign acc_op  = op_t'(cmd_op);
   // The memory flags mirror depth; OR-ing them in keeps a corrupted count from overrunning the memory.
   assign is_full  = (depth_q == 6'd32) | mem_full;
   assign is_empty = (depth_q == 6'd0)  | mem_empty;

   // Stack pops B first (top), queue pops A first (head).
   always_comb begin
      opa     = mode_q ? opr_q   : rd_data;
      opb     = mode_q ? rd_data : opr_q;
      alu_res = '0;
      case (op_q)
         OP_ADD: alu_res = opa + opb;
         OP_SUB: alu_res = opa - opb;
`ifdef CALC_MUL_EN
         OP_MUL: alu_res = opa * opb;
`endif
         OP_AND: alu_res = opa & opb;
         OP_OR:  alu_res = opa | opb;
         OP_XOR: alu_res = opa ^ opb;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      acc_code = RC_OK;
      if (acc_op == OP_MUL && !MUL_EN)                      acc_code = RC_ILL;
      else if (acc_op == OP_PUSH && is_full)                acc_code = RC_OVER;
      else if (acc_op == OP_POP && is_empty)                acc_code = RC_UNDER;
      else if (acc_op != OP_PUSH && acc_op != OP_POP && depth_q < 6'd2) acc_code = RC_UNDER;
   end

   // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      mode_d     = mode_q;
      data_d     = data_q;
      opr_d      = opr_q;
      depth_d    = depth_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      rsp_code_d = rsp_code_q;
      mem_push   = 1'b0;
      mem_pop    = 1'b0;
      mem_dataIn = '0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d   = acc_op;
               mode_d = cmd_mode;
               data_d = cmd_data;
               if (acc_code != RC_OK) begin
                  rsp_err_d  = 1'b1;
                  rsp_code_d = acc_code;
                  rsp_data_d = '0;
                  state_d    = S_RESP;
               end else begin
                  state_d = (acc_op == OP_PUSH) ? S_PUSHW : S_POP1;
               end
            end
         end
         S_POP1: begin
            mem_pop = 1'b1;
            depth_d = depth_q - 6'd1;
            if (op_q == OP_POP) begin
               rsp_data_d = rd_data;
               rsp_err_d  = 1'b0;
               rsp_code_d = RC_OK;
               state_d    = S_RESP;
            end else begin
               opr_d   = rd_data;
               state_d = S_POP2;
            end
         end
         S_POP2: begin
            mem_pop = 1'b1;
            depth_d = depth_q - 6'd1;
            data_d  = alu_res;
            state_d = S_PUSHW;
         end
         S_PUSHW: begin
            mem_push   = 1'b1;
            mem_dataIn = data_q;
            depth_d    = depth_q + 6'd1;
            rsp_data_d = data_q;
            rsp_err_d  = 1'b0;
            rsp_code_d = RC_OK;
            state_d    = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         op_q       <= OP_PUSH;
         mode_q     <= 1'b0;
         data_q     <= '0;
         opr_q      <= '0;
         depth_q    <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         rsp_code_q <= RC_OK;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         mode_q     <= mode_d;
         data_q     <= data_d;
         opr_q      <= opr_d;
         depth_q    <= depth_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         rsp_code_q <= rsp_code_d;
      end
   end

   assign cmd_ready      = (state_q == S_IDLE);
   assign rsp_valid      = (state_q == S_RESP);
   assign mem_stackQueue = mode_q;
   assign rsp_data       = rsp_data_q;
   assign rsp_err        = rsp_err_q;
   assign rsp_code       = rsp_code_q;
   assign depth          = depth_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer with a behavioural 32-entry stack/queue memory.
// Expectations for op 011 follow CALC_MUL_EN.
module tb_calc_sequencer;

   localparam logic [2:0] PUSH = 3'd0, ADD = 3'd1, SUB = 3'd2, MUL = 3'd3,
                          AND_ = 3'd4, OR_ = 3'd5, XOR_ = 3'd6, POP = 3'd7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = 3'd0;
   logic [31:0] cmd_data = '0;
   logic        cmd_mode = 1'b0;
   logic        mem_push, mem_pop, mem_stackQueue;
   logic [31:0] mem_dataIn, mem_stackOut, mem_queueOut;
   logic        mem_empty, mem_full;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_code;
   logic [5:0]  depth;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   calc_sequencer dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .cmd_mode(cmd_mode),
      .mem_push(mem_push), .mem_pop(mem_pop), .mem_stackQueue(mem_stackQueue),
      .mem_dataIn(mem_dataIn), .mem_stackOut(mem_stackOut), .mem_queueOut(mem_queueOut),
      .mem_empty(mem_empty), .mem_full(mem_full),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .rsp_code(rsp_code), .depth(depth)
   );

   // Memory model: circular buffer; stack pops the tail, queue pops the head, pushes go to the tail.
   logic [31:0] mem_q [32];
   logic [4:0]  head_q;
   logic [5:0]  cnt_q;
   logic [4:0]  top_idx, tail_idx;
   logic        mem_rst_n;

   assign mem_rst_n    = ~rst;
   assign top_idx      = head_q + cnt_q[4:0] - 5'd1;
   assign tail_idx     = head_q + cnt_q[4:0];
   assign mem_stackOut = (cnt_q == 6'd0) ? 32'd0 : mem_q[top_idx];
   assign mem_queueOut = (cnt_q == 6'd0) ? 32'd0 : mem_q[head_q];
   assign mem_empty    = (cnt_q == 6'd0);
   assign mem_full     = (cnt_q == 6'd32);

   always_ff @(posedge clk) begin
      if (!mem_rst_n) begin
         head_q <= '0;
         cnt_q  <= '0;
      end else if (mem_push && cnt_q < 6'd32) begin
         mem_q[tail_idx] <= mem_dataIn;
         cnt_q           <= cnt_q + 6'd1;
      end else if (mem_pop && cnt_q > 6'd0) begin
         if (mem_stackQueue) head_q <= head_q + 5'd1;
         cnt_q <= cnt_q - 6'd1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Structural invariants, every cycle outside reset.
   always @(negedge clk) begin
      if (!rst) begin
         check("strobe_exclusive", 32'(mem_push & mem_pop), 32'd0);
         check("empty_vs_depth", 32'(mem_empty), 32'(depth == 6'd0));
         check("full_vs_depth", 32'(mem_full), 32'(depth == 6'd32));
      end
   end

   typedef struct {
      logic [2:0]  op;
      logic [31:0] data;
      logic        mode;
      logic [31:0] exp_data;
      logic        exp_err;
      logic [1:0]  exp_code;
      logic [5:0]  exp_depth;
      int          exp_lat;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [2:0] op, input logic [31:0] data, input logic mode,
                               input logic [31:0] ed, input logic ee, input logic [1:0] ec,
                               input logic [5:0] edp, input int el);
      vec_t v;
      v.op = op; v.data = data; v.mode = mode; v.exp_data = ed; v.exp_err = ee;
      v.exp_code = ec; v.exp_depth = edp; v.exp_lat = el;
      return v;
   endfunction

   // Issue one command and wait (bounded) for its response pulse.
   task automatic do_cmd(input logic [2:0] op, input logic [31:0] data, input logic mode,
                         output logic [31:0] r_data, output logic r_err, output logic [1:0] r_code,
                         output logic [5:0] r_depth, output int lat, output logic saw_push);
      logic done;
      @(negedge clk);
      check("cmd_ready_before", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_mode  = mode;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_data  = 32'hDEAD_BEEF;
      cmd_mode  = ~mode;
      done = 1'b0; lat = 0; saw_push = 1'b0;
      r_data = '0; r_err = 1'b0; r_code = '0; r_depth = '0;
      for (int c = 1; c <= 8 && !done; c++) begin
         @(negedge clk);
         if (c == 1) check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
         if (mem_push) saw_push = 1'b1;
         if (rsp_valid) begin
            done = 1'b1; lat = c;
            r_data = rsp_data; r_err = rsp_err; r_code = rsp_code; r_depth = depth;
         end
      end
      check("rsp_arrived", 32'(done), 32'd1);
      @(negedge clk);
      check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
      check("rsp_data_held", rsp_data, r_data);
      check("cmd_ready_after", 32'(cmd_ready), 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      logic [31:0] d; logic e; logic [1:0] c; logic [5:0] dp; int lat; logic sp;
      do_cmd(v.op, v.data, v.mode, d, e, c, dp, lat, sp);
      check({tag, "_data"},  d, v.exp_data);
      check({tag, "_err"},   32'(e), 32'(v.exp_err));
      check({tag, "_code"},  32'(c), 32'(v.exp_code));
      check({tag, "_depth"}, 32'(dp), 32'(v.exp_depth));
      check({tag, "_lat"},   32'(lat), 32'(v.exp_lat));
      if (v.exp_err) check({tag, "_no_push"}, 32'(sp), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic saw_rsp;

      // Stack arithmetic, underflow cases
      vecs.push_back(mk(PUSH, 32'd5, 1'b0, 32'd5, 1'b0, 2'b00, 6'd1, 2));
      vecs.push_back(mk(PUSH, 32'd3, 1'b0, 32'd3, 1'b0, 2'b00, 6'd2, 2));
      vecs.push_back(mk(SUB,  32'd0, 1'b0, 32'd2, 1'b0, 2'b00, 6'd1, 4));
      vecs.push_back(mk(POP,  32'd0, 1'b0, 32'd2, 1'b0, 2'b00, 6'd0, 2));
      vecs.push_back(mk(POP,  32'd0, 1'b0, 32'd0, 1'b1, 2'b01, 6'd0, 1));
      vecs.push_back(mk(PUSH, 32'd1, 1'b0, 32'd1, 1'b0, 2'b00, 6'd1, 2));
      vecs.push_back(mk(XOR_, 32'd0, 1'b0, 32'd0, 1'b1, 2'b01, 6'd1, 1));
      vecs.push_back(mk(POP,  32'd0, 1'b0, 32'd1, 1'b0, 2'b00, 6'd0, 2));
      // Queue mode: 10-4 enqueued behind 7
      vecs.push_back(mk(PUSH, 32'd10, 1'b1, 32'd10, 1'b0, 2'b00, 6'd1, 2));
      vecs.push_back(mk(PUSH, 32'd4,  1'b1, 32'd4,  1'b0, 2'b00, 6'd2, 2));
      vecs.push_back(mk(PUSH, 32'd7,  1'b1, 32'd7,  1'b0, 2'b00, 6'd3, 2));
      vecs.push_back(mk(SUB,  32'd0,  1'b1, 32'd6,  1'b0, 2'b00, 6'd2, 4));
      vecs.push_back(mk(POP,  32'd0,  1'b1, 32'd7,  1'b0, 2'b00, 6'd1, 2));
      vecs.push_back(mk(POP,  32'd0,  1'b1, 32'd6,  1'b0, 2'b00, 6'd0, 2));
      // Wraparound add, then MUL
      vecs.push_back(mk(PUSH, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 2'b00, 6'd1, 2));
      vecs.push_back(mk(PUSH, 32'd2, 1'b0, 32'd2, 1'b0, 2'b00, 6'd2, 2));
      vecs.push_back(mk(ADD,  32'd0, 1'b0, 32'd1, 1'b0, 2'b00, 6'd1, 4));
      vecs.push_back(mk(PUSH, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 2'b00, 6'd2, 2));
`ifdef CALC_MUL_EN
      vecs.push_back(mk(MUL,  32'd0, 1'b0, 32'h8000_0000, 1'b0, 2'b00, 6'd1, 4));
      vecs.push_back(mk(POP,  32'd0, 1'b0, 32'h8000_0000, 1'b0, 2'b00, 6'd0, 2));
`else
      vecs.push_back(mk(MUL,  32'd0, 1'b0, 32'd0, 1'b1, 2'b11, 6'd2, 1));
      vecs.push_back(mk(POP,  32'd0, 1'b0, 32'h8000_0000, 1'b0, 2'b00, 6'd1, 2));
      vecs.push_back(mk(POP,  32'd0, 1'b0, 32'd1, 1'b0, 2'b00, 6'd0, 2));
`endif
      // Bitwise ops
      vecs.push_back(mk(PUSH, 32'hF0F0_F0F0, 1'b0, 32'hF0F0_F0F0, 1'b0, 2'b00, 6'd1, 2));
      vecs.push_back(mk(PUSH, 32'hFF00_FF00, 1'b0, 32'hFF00_FF00, 1'b0, 2'b00, 6'd2, 2));
      vecs.push_back(mk(AND_, 32'd0, 1'b0, 32'hF000_F000, 1'b0, 2'b00, 6'd1, 4));
      vecs.push_back(mk(PUSH, 32'h0000_000F, 1'b0, 32'h0000_000F, 1'b0, 2'b00, 6'd2, 2));
      vecs.push_back(mk(OR_,  32'd0, 1'b0, 32'hF000_F00F, 1'b0, 2'b00, 6'd1, 4));
      vecs.push_back(mk(PUSH, 32'h0F0F_0000, 1'b0, 32'h0F0F_0000, 1'b0, 2'b00, 6'd2, 2));
      vecs.push_back(mk(XOR_, 32'd0, 1'b0, 32'hFF0F_F00F, 1'b0, 2'b00, 6'd1, 4));
      vecs.push_back(mk(POP,  32'd0, 1'b0, 32'hFF0F_F00F, 1'b0, 2'b00, 6'd0, 2));

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_mem_push", 32'(mem_push), 32'd0);
      check("rst_mem_pop", 32'(mem_pop), 32'd0);
      check("rst_stackQueue", 32'(mem_stackQueue), 32'd0);
      check("rst_dataIn", mem_dataIn, 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_rsp_code", 32'(rsp_code), 32'd0);
      check("rst_depth", 32'(depth), 32'd0);

      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Fill to 32, overflow, then a binary op frees one slot
      for (int i = 0; i < 32; i++)
         run_vec(mk(PUSH, 32'(i), 1'b0, 32'(i), 1'b0, 2'b00, 6'(i + 1), 2), $sformatf("fill%0d", i));
      check("fill_mem_full", 32'(mem_full), 32'd1);
      run_vec(mk(PUSH, 32'd77, 1'b0, 32'd0, 1'b1, 2'b10, 6'd32, 1), "overflow");
      run_vec(mk(ADD,  32'd0,  1'b0, 32'd61, 1'b0, 2'b00, 6'd31, 4), "add_full");
      run_vec(mk(PUSH, 32'd99, 1'b0, 32'd99, 1'b0, 2'b00, 6'd32, 2), "push_after");
      do_reset();

      // Reset during POP2 of an ADD
      run_vec(mk(PUSH, 32'd1, 1'b0, 32'd1, 1'b0, 2'b00, 6'd1, 2), "abort_p1");
      run_vec(mk(PUSH, 32'd2, 1'b0, 32'd2, 1'b0, 2'b00, 6'd2, 2), "abort_p2");
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = ADD; cmd_mode = 1'b0;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      check("abort_pop1", 32'(mem_pop), 32'd1);
      @(negedge clk);
      check("abort_pop2", 32'(mem_pop), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_ready", 32'(cmd_ready), 32'd1);
      check("abort_depth", 32'(depth), 32'd0);
      check("abort_empty", 32'(mem_empty), 32'd1);
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      saw_rsp = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid || mem_push) saw_rsp = 1'b1;
      end
      check("abort_no_rsp", 32'(saw_rsp), 32'd0);
      run_vec(mk(POP, 32'd0, 1'b0, 32'd0, 1'b1, 2'b01, 6'd0, 1), "abort_pop_empty");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
